except_ctrl: RTL and testbench

// - Commit-point exception controller: drives except_type/pc/delayslot/mem_addr into cp0_reg, flush/redirect out to the pipeline.
// - Prioritises MEM-stage exception flags, synchronises external interrupt lines, forwards in-flight WB CP0 writes.
// - Holds a post-exception flush window during which younger instructions cannot raise exceptions.

---
 rtl/except_pkg.sv | 38 +++
 rtl/int_sync.sv | 29 ++
 rtl/except_ctrl.sv | 150 +++++++++++++++
 tb/tb_except_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/except_pkg.sv
// Shared constants for the commit-point exception controller and cp0_reg.
package except_pkg;

    // Exception codes driven on except_type_o.
    localparam logic [31:0] EXC_NONE   = 32'h0000_0000;
    localparam logic [31:0] EXC_INT    = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL_D = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES   = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS    = 32'h0000_0008;
    localparam logic [31:0] EXC_BRK    = 32'h0000_0009;
    localparam logic [31:0] EXC_RI     = 32'h0000_000a;
    localparam logic [31:0] EXC_OV     = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
    localparam logic [31:0] EXC_ADEL_F = 32'h0000_000f;

    // Bit positions inside exc_flags_i.
    localparam int unsigned FLG_ADEL_F = 0;
    localparam int unsigned FLG_RI     = 1;
    localparam int unsigned FLG_SYS    = 2;
    localparam int unsigned FLG_BRK    = 3;
    localparam int unsigned FLG_OV     = 4;
    localparam int unsigned FLG_TRAP   = 5;
    localparam int unsigned FLG_ADEL_D = 6;
    localparam int unsigned FLG_ADES   = 7;
    localparam int unsigned FLG_ERET   = 8;

    // CP0 register addresses.
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } exc_state_e;

endpackage

// File: rtl/int_sync.sv
// Multi-stage synchroniser for the external interrupt lines.
module int_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] int_i,
    output logic [5:0] int_o
);

    logic [5:0] sync_q [SYNC_STAGES];

    // Shift the raw lines through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= int_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign int_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/except_ctrl.sv
// Commit-point exception controller: prioritises MEM exceptions, forwards
// WB CP0 writes, and holds a flush window after each accepted exception.
module except_ctrl
    import except_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] cp0_vector_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] except_type_o,
    output logic [31:0] pc_o,
    output logic        delayslot_o,
    output logic [31:0] mem_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    exc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    sync_int;
    logic [31:0]   status_eff, cause_eff, epc_eff;
    logic          irq;
    logic [31:0]   code;
    logic [31:0]   exc_type_d, new_pc_d;
    logic          flush_d;
    logic          unused_bits;

    int_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .rst   (rst),
        .int_i (int_i),
        .int_o (sync_int)
    );

    // Timer bypasses the synchroniser; gated so reset forces all lines low.
    assign int_o = {sync_int[5] | (timer_int_i & ~rst), sync_int[4:0]};

    assign pc_o        = mem_pc_i;
    assign delayslot_o = mem_delayslot_i;
    assign mem_addr_o  = mem_addr_i;

    // Forward the in-flight WB CP0 write into the effective CP0 view.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            unique case (wb_cp0_waddr_i)
                CP0_STATUS: begin
                    status_eff[22]   = wb_cp0_data_i[22];
                    status_eff[15:8] = wb_cp0_data_i[15:8];
                    status_eff[1:0]  = wb_cp0_data_i[1:0];
                end
                CP0_CAUSE: begin
                    cause_eff[23:22] = wb_cp0_data_i[23:22];
                    cause_eff[9:8]   = wb_cp0_data_i[9:8];
                end
                CP0_EPC: epc_eff = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    assign irq = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));
    assign unused_bits = ^{status_eff, cause_eff};

    // Priority encode the MEM-stage exception sources.
    always_comb begin
        code = EXC_NONE;
        if (mem_valid_i) begin
            if      (irq)                     code = EXC_INT;
            else if (exc_flags_i[FLG_ADEL_F]) code = EXC_ADEL_F;
            else if (exc_flags_i[FLG_RI])     code = EXC_RI;
            else if (exc_flags_i[FLG_SYS])    code = EXC_SYS;
            else if (exc_flags_i[FLG_BRK])    code = EXC_BRK;
            else if (exc_flags_i[FLG_OV])     code = EXC_OV;
            else if (exc_flags_i[FLG_TRAP])   code = EXC_TRAP;
            else if (exc_flags_i[FLG_ADEL_D]) code = EXC_ADEL_D;
            else if (exc_flags_i[FLG_ADES])   code = EXC_ADES;
            else if (exc_flags_i[FLG_ERET])   code = EXC_ERET;
        end
    end

    // Next-state and output logic of the accept/flush FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        exc_type_d = '0;
        flush_d    = 1'b0;
        new_pc_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                exc_type_d = code;
                if (code != EXC_NONE) begin
                    flush_d  = 1'b1;
                    new_pc_d = (code == EXC_ERET) ? epc_eff : cp0_vector_i;
                    if (FLUSH_CYCLES > 0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES);
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are combinational, so reset must mask them explicitly.
    assign except_type_o = rst ? '0 : exc_type_d;
    assign flush_o       = rst ? 1'b0 : flush_d;
    assign new_pc_o      = rst ? '0 : new_pc_d;

    // State and flush-window counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl (FLUSH_CYCLES=1, SYNC_STAGES=2).
module tb_except_ctrl;
    import except_pkg::*;

    localparam logic [31:0] VEC = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [5:0]  int_o;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_delayslot_i;
    logic [31:0] mem_addr_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_vector_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] except_type_o, pc_o, mem_addr_o, new_pc_o;
    logic        delayslot_o, flush_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] code;
        logic        flush;
        logic [31:0] new_pc;
        logic [5:0]  intv;
    } exp_t;

    exp_t sb[$];

    except_ctrl #(
        .FLUSH_CYCLES (1),
        .SYNC_STAGES  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .int_i           (int_i),
        .timer_int_i     (timer_int_i),
        .int_o           (int_o),
        .mem_valid_i     (mem_valid_i),
        .mem_pc_i        (mem_pc_i),
        .mem_delayslot_i (mem_delayslot_i),
        .mem_addr_i      (mem_addr_i),
        .exc_flags_i     (exc_flags_i),
        .cp0_status_i    (cp0_status_i),
        .cp0_cause_i     (cp0_cause_i),
        .cp0_epc_i       (cp0_epc_i),
        .cp0_vector_i    (cp0_vector_i),
        .wb_cp0_we_i     (wb_cp0_we_i),
        .wb_cp0_waddr_i  (wb_cp0_waddr_i),
        .wb_cp0_data_i   (wb_cp0_data_i),
        .except_type_o   (except_type_o),
        .pc_o            (pc_o),
        .delayslot_o     (delayslot_o),
        .mem_addr_o      (mem_addr_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [31:0] code, logic flush,
                        logic [31:0] new_pc, logic [5:0] intv);
        exp_t e;
        e.tag = tag; e.code = code; e.flush = flush; e.new_pc = new_pc; e.intv = intv;
        sb.push_back(e);
    endtask

    // Wait for the mid-cycle sample point and retire every queued expectation.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".code"},  except_type_o,           e.code);
            chk({e.tag, ".flush"}, {31'd0, flush_o},        {31'd0, e.flush});
            chk({e.tag, ".newpc"}, new_pc_o,                e.new_pc);
            chk({e.tag, ".int"},   {26'd0, int_o},          {26'd0, e.intv});
        end
    endtask

    task automatic step(string tag, logic [31:0] code, logic flush,
                        logic [31:0] new_pc, logic [5:0] intv);
        push(tag, code, flush, new_pc, intv);
        sample();
    endtask

    // Advance to just after the next rising edge with single-cycle inputs cleared.
    task automatic cyc();
        @(posedge clk);
        #1;
        exc_flags_i = '0;
        wb_cp0_we_i = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        int_i           = 6'h3f;
        timer_int_i     = 1'b1;
        mem_valid_i     = 1'b1;
        mem_pc_i        = 32'h0;
        mem_delayslot_i = 1'b0;
        mem_addr_i      = 32'h0;
        exc_flags_i     = 9'h004;
        cp0_status_i    = 32'h0000_0001;
        cp0_cause_i     = 32'h0;
        cp0_epc_i       = 32'h0;
        cp0_vector_i    = VEC;
        wb_cp0_we_i     = 1'b0;
        wb_cp0_waddr_i  = 5'd0;
        wb_cp0_data_i   = 32'h0;
        step("reset", 32'h0, 1'b0, 32'h0, 6'h00);

        cyc(); rst = 1'b0; int_i = 6'h00; timer_int_i = 1'b0; mem_valid_i = 1'b0;
        step("idle", 32'h0, 1'b0, 32'h0, 6'h00);

        // Synchroniser latency: two edges after int_i rises.
        cyc(); int_i = 6'h01;
        step("sync0", 32'h0, 1'b0, 32'h0, 6'h00);
        cyc();
        step("sync1", 32'h0, 1'b0, 32'h0, 6'h00);
        cyc();
        step("sync2", 32'h0, 1'b0, 32'h0, 6'h01);
        cyc(); timer_int_i = 1'b1;
        step("timer", 32'h0, 1'b0, 32'h0, 6'h21);
        timer_int_i = 1'b0;

        // Syscall with pass-through of pc/delayslot/address.
        cyc(); mem_valid_i = 1'b1; exc_flags_i[FLG_SYS] = 1'b1;
        mem_pc_i = 32'hbfc0_0100; mem_delayslot_i = 1'b1; mem_addr_i = 32'h1234_5678;
        step("sys", EXC_SYS, 1'b1, VEC, 6'h01);
        chk("sys.pc", pc_o, 32'hbfc0_0100);
        chk("sys.ds", {31'd0, delayslot_o}, 32'd1);
        chk("sys.addr", mem_addr_o, 32'h1234_5678);
        cyc();
        step("sys_flush", 32'h0, 1'b1, 32'h0, 6'h01);
        cyc(); mem_delayslot_i = 1'b0;
        step("sys_done", 32'h0, 1'b0, 32'h0, 6'h01);

        // Priority cases.
        cyc(); exc_flags_i[FLG_SYS] = 1'b1; exc_flags_i[FLG_OV] = 1'b1;
        step("pri_sys_ov", EXC_SYS, 1'b1, VEC, 6'h01);
        cyc();
        step("pri1_flush", 32'h0, 1'b1, 32'h0, 6'h01);
        cyc(); exc_flags_i[FLG_RI] = 1'b1; exc_flags_i[FLG_ADEL_F] = 1'b1;
        step("pri_ri_adelf", EXC_ADEL_F, 1'b1, VEC, 6'h01);
        cyc();
        step("pri2_flush", 32'h0, 1'b1, 32'h0, 6'h01);

        // WB STATUS write clearing IE suppresses the pending interrupt.
        cyc(); cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = CP0_STATUS; wb_cp0_data_i = 32'h0000_0400;
        step("fwd_ie0", 32'h0, 1'b0, 32'h0, 6'h01);
        // WB STATUS write setting IE makes it taken.
        cyc(); cp0_status_i = 32'h0000_0400;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = CP0_STATUS; wb_cp0_data_i = 32'h0000_0401;
        step("fwd_ie1", EXC_INT, 1'b1, VEC, 6'h01);
        cyc();
        step("fwd_flush", 32'h0, 1'b1, 32'h0, 6'h01);
        // Pending interrupt on a bubble is not taken.
        cyc(); cp0_status_i = 32'h0000_0401; mem_valid_i = 1'b0;
        step("irq_bubble", 32'h0, 1'b0, 32'h0, 6'h01);
        cyc(); cp0_status_i = 32'h0000_0001; cp0_cause_i = 32'h0; mem_valid_i = 1'b1;

        // eret with EPC forwarded from WB.
        cp0_epc_i = 32'h1111_0000; exc_flags_i[FLG_ERET] = 1'b1;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = CP0_EPC; wb_cp0_data_i = 32'h8000_1234;
        step("eret_fwd", EXC_ERET, 1'b1, 32'h8000_1234, 6'h01);
        cyc();
        step("eret_flush", 32'h0, 1'b1, 32'h0, 6'h01);
        cyc(); exc_flags_i[FLG_ERET] = 1'b1; exc_flags_i[FLG_ADEL_D] = 1'b1;
        step("eret_adeld", EXC_ADEL_D, 1'b1, VEC, 6'h01);
        cyc();
        step("eret2_flush", 32'h0, 1'b1, 32'h0, 6'h01);

        // Flush window masks a younger exception for one cycle.
        cyc(); exc_flags_i[FLG_RI] = 1'b1;
        step("win_T", EXC_RI, 1'b1, VEC, 6'h01);
        cyc(); exc_flags_i[FLG_RI] = 1'b1;
        step("win_T1", 32'h0, 1'b1, 32'h0, 6'h01);
        cyc(); exc_flags_i[FLG_RI] = 1'b1;
        step("win_T2", EXC_RI, 1'b1, VEC, 6'h01);
        cyc();
        step("win_flush", 32'h0, 1'b1, 32'h0, 6'h01);
        cyc(); exc_flags_i[FLG_BRK] = 1'b1; mem_valid_i = 1'b0;
        step("brk_bubble", 32'h0, 1'b0, 32'h0, 6'h01);

        // Reset asserted in the middle of the flush window.
        cyc(); mem_valid_i = 1'b1; exc_flags_i[FLG_SYS] = 1'b1;
        step("rst_pre", EXC_SYS, 1'b1, VEC, 6'h01);
        cyc(); rst = 1'b1; exc_flags_i[FLG_SYS] = 1'b1;
        step("rst_mid", 32'h0, 1'b0, 32'h0, 6'h00);
        cyc(); rst = 1'b0; exc_flags_i[FLG_SYS] = 1'b1;
        step("rst_after", EXC_SYS, 1'b1, VEC, 6'h00);
        cyc();
        step("rst_flush", 32'h0, 1'b1, 32'h0, 6'h00);
        cyc();
        step("rst_sync", 32'h0, 1'b0, 32'h0, 6'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
